// File: rtl/prog_timer_if.sv
// Handshake bundle between a timer client and prog_timer. The master drives
// the load/run/abort controls, and the timer (slave) returns its status.
interface prog_timer_if #(
    parameter int COUNT_W = 4
) ();
    logic [COUNT_W-1:0] value;
    logic               start;
    logic               abort;
    logic               auto_reload;
    logic               one_hz_enable;
    logic               two_hz_enable;
    logic               busy;
    logic               expired;
    logic               done;
    logic [COUNT_W-1:0] remaining;

    modport master (
        output value, start, abort, auto_reload,
        input  one_hz_enable, two_hz_enable, busy, expired, done, remaining
    );

    modport slave (
        input  value, start, abort, auto_reload,
        output one_hz_enable, two_hz_enable, busy, expired, done, remaining
    );
endinterface

// File: rtl/prog_timer.sv
// Programmable countdown timer with free-running 1 Hz / 2 Hz prescalers.
// Optional macro TIMER_ALIGN_EN: an accepted start also clears both prescalers.
module prog_timer #(
    parameter int ONE_HZ_MAX = 100_000_000,
    parameter int TWO_HZ_MAX = 50_000_000,
    parameter int COUNT_W    = 4
) (
    input  logic        clock,
    input  logic        reset,
    prog_timer_if.slave tmr
);

    localparam int P1_W = (ONE_HZ_MAX > 1) ? $clog2(ONE_HZ_MAX) : 1;
    localparam int P2_W = (TWO_HZ_MAX > 1) ? $clog2(TWO_HZ_MAX) : 1;
    localparam logic [P1_W-1:0] P1_LAST = P1_W'(ONE_HZ_MAX - 1);
    localparam logic [P2_W-1:0] P2_LAST = P2_W'(TWO_HZ_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [P1_W-1:0]    pre1_q, pre1_d;
    logic [P2_W-1:0]    pre2_q, pre2_d;
    logic               one_hz_q, one_hz_d;
    logic               two_hz_q, two_hz_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [COUNT_W-1:0] reload_q, reload_d;
    logic               periodic_q, periodic_d;
    logic               done_q, done_d;
    logic               expired_q, expired_d;
    logic               busy_q, busy_d;
    logic               start_acc_s;
    logic               align_clr_s;

    // abort outranks start, so a start in the same cycle as abort is dropped
    assign start_acc_s = tmr.start & ~tmr.abort;

`ifdef TIMER_ALIGN_EN
    assign align_clr_s = start_acc_s;
`else
    assign align_clr_s = 1'b0;
`endif

    // 1 Hz prescaler next state; the enable register is cleared on alignment
    // too, so no stale pulse can land right after an aligned start.
    always_comb begin
        pre1_d   = pre1_q;
        one_hz_d = 1'b0;
        if (align_clr_s) begin
            pre1_d   = {P1_W{1'b0}};
            one_hz_d = 1'b0;
        end else if (pre1_q == P1_LAST) begin
            pre1_d   = {P1_W{1'b0}};
            one_hz_d = 1'b1;
        end else begin
            pre1_d   = pre1_q + P1_W'(1);
            one_hz_d = 1'b0;
        end
    end

    // 2 Hz prescaler next state
    always_comb begin
        pre2_d   = pre2_q;
        two_hz_d = 1'b0;
        if (align_clr_s) begin
            pre2_d   = {P2_W{1'b0}};
            two_hz_d = 1'b0;
        end else if (pre2_q == P2_LAST) begin
            pre2_d   = {P2_W{1'b0}};
            two_hz_d = 1'b1;
        end else begin
            pre2_d   = pre2_q + P2_W'(1);
            two_hz_d = 1'b0;
        end
    end

    // Controller next state: abort, then start, then the 1 Hz tick
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        reload_d    = reload_q;
        periodic_d  = periodic_q;
        done_d      = done_q;
        expired_d   = 1'b0;
        if (tmr.abort) begin
            state_d     = ST_IDLE;
            remaining_d = {COUNT_W{1'b0}};
            done_d      = 1'b0;
        end else if (tmr.start) begin
            state_d     = ST_RUN;
            remaining_d = tmr.value;
            reload_d    = tmr.value;
            periodic_d  = tmr.auto_reload;
            done_d      = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!one_hz_q) begin
                        state_d = ST_RUN;
                    end else if (remaining_q != {COUNT_W{1'b0}}) begin
                        remaining_d = remaining_q - COUNT_W'(1);
                    end else begin
                        expired_d = 1'b1;
                        if (periodic_q) begin
                            remaining_d = reload_q;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_IDLE: state_d = ST_IDLE;
                ST_DONE: state_d = ST_DONE;
                default: begin
                    state_d     = ST_IDLE;
                    remaining_d = {COUNT_W{1'b0}};
                    done_d      = 1'b0;
                end
            endcase
        end
        busy_d = (state_d == ST_RUN);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pre1_q      <= {P1_W{1'b0}};
            pre2_q      <= {P2_W{1'b0}};
            one_hz_q    <= 1'b0;
            two_hz_q    <= 1'b0;
            remaining_q <= {COUNT_W{1'b0}};
            reload_q    <= {COUNT_W{1'b0}};
            periodic_q  <= 1'b0;
            done_q      <= 1'b0;
            expired_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre1_q      <= pre1_d;
            pre2_q      <= pre2_d;
            one_hz_q    <= one_hz_d;
            two_hz_q    <= two_hz_d;
            remaining_q <= remaining_d;
            reload_q    <= reload_d;
            periodic_q  <= periodic_d;
            done_q      <= done_d;
            expired_q   <= expired_d;
            busy_q      <= busy_d;
        end
    end

    assign tmr.one_hz_enable = one_hz_q;
    assign tmr.two_hz_enable = two_hz_q;
    assign tmr.busy          = busy_q;
    assign tmr.expired       = expired_q;
    assign tmr.done          = done_q;
    assign tmr.remaining     = remaining_q;

endmodule
